// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port block-memory arbiter.
//   - state_t  : arbiter FSM states (encoding matches the grant code one-for-one)
//   - last_t   : which port was granted most recently (round-robin memory)
//   - GNT_*    : grant output codes
//   - MEM_ADDR_W / MEM_DATA_W : default block address and block data widths
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Grant code presented for a given FSM state.
  function automatic logic [1:0] grant_of(input state_t s);
    case (s)
      S_GNT_I: grant_of = GNT_I;
      S_GNT_D: grant_of = GNT_D;
      default: grant_of = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_mux.sv
// mem_arb_mux: combinational steering between the I and D requesters and memory.
//   grant                      : selects which port drives memory (00 none, 01 I, 10 D)
//   i_* / d_* request fields   : read, write, addr, wdata from each cache
//   mem_read/write/addr/wdata  : steered request to memory, all zero with no grant
//   mem_ready                  : memory completion, routed only to the granted port
//   i_ready / d_ready          : per-port completion
module mem_arb_mux
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic [1:0]        grant,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_ready,
  output logic              d_ready
);

  // Read and write both high is a protocol error; the write wins.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (grant)
      GNT_I: begin
        mem_read  = i_read & ~i_write;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
      end
      GNT_D: begin
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block-memory port between the
// instruction cache (I) and data cache (D). A grant is held across a dirty
// write-back and its allocate read so each miss is atomic.
//   clk, proc_reset            : clock, asynchronous active-high reset
//   i_* / d_*                  : requester read/write/addr/wdata in, rdata/ready out
//   mem_*                      : memory request out, rdata/ready in
//   grant                      : current owner (00 none, 01 I, 10 D)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  state_t state_reg;
  last_t  last_gnt_reg;

  logic req_i;
  logic req_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // Read data needs no steering; the ready gating tells each port when it is valid.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign grant = grant_of(state_reg);

  // Release on a read completion (a read always ends a miss) or when the owner
  // drops its request. A write completion keeps the grant for the allocate read.
  // The owner's "read" is only effective without write, so a completion that
  // coincides with a write never releases.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_reg    <= S_IDLE;
      last_gnt_reg <= LAST_I;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // I wins when it is alone, or when both request and D went last.
          if (req_i && (!req_d || last_gnt_reg == LAST_D)) begin
            state_reg    <= S_GNT_I;
            last_gnt_reg <= LAST_I;
          end else if (req_d) begin
            state_reg    <= S_GNT_D;
            last_gnt_reg <= LAST_D;
          end
        end
        S_GNT_I: begin
          if (!req_i || (mem_ready && !i_write))
            state_reg <= S_IDLE;
        end
        S_GNT_D: begin
          if (!req_d || (mem_ready && !d_write))
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  mem_arb_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .grant     (grant),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .i_ready   (i_ready),
    .d_ready   (d_ready)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with hand-computed
// expectations. Inputs change 1 ns after the rising edge; outputs are sampled
// a further 1 ns later, away from the edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_ready, d_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        grant;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [DATA_W-1:0] PAT_A5   = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_1234 = {8{16'h1234}};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .grant      (grant)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s ok: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one read for the port expected to own the grant, then confirm release.
  task automatic serve_read(input logic [1:0] exp_gnt, input string tag);
    step();
    check({tag, " grant"}, 128'(grant), 128'(exp_gnt));
    mem_rdata = PAT_A5;
    mem_ready = 1'b1;
    #1;
    check({tag, " i_ready"}, 128'(i_ready), 128'(exp_gnt == 2'b01));
    check({tag, " d_ready"}, 128'(d_ready), 128'(exp_gnt == 2'b10));
    step();
    mem_ready = 1'b0;
    check({tag, " released"}, 128'(grant), 128'(2'b00));
  endtask

  initial begin
    proc_reset = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;

    // Reset state
    step();
    check("rst grant", 128'(grant), 128'(2'b00));
    check("rst mem_read", 128'(mem_read), 128'(1'b0));
    check("rst mem_addr", 128'(mem_addr), 128'(0));
    proc_reset = 1'b0;

    // I read alone at 0x0000010
    i_read = 1'b1;
    i_addr = 28'h0000010;
    step();
    check("i_rd grant", 128'(grant), 128'(2'b01));
    check("i_rd mem_read", 128'(mem_read), 128'(1'b1));
    check("i_rd mem_write", 128'(mem_write), 128'(1'b0));
    check("i_rd mem_addr", 128'(mem_addr), 128'(28'h0000010));
    mem_rdata = PAT_A5;
    mem_ready = 1'b1;
    #1;
    check("i_rd i_ready", 128'(i_ready), 128'(1'b1));
    check("i_rd i_rdata", i_rdata, PAT_A5);
    check("i_rd d_ready", 128'(d_ready), 128'(1'b0));
    step();
    mem_ready = 1'b0;
    i_read = 1'b0;
    check("i_rd released", 128'(grant), 128'(2'b00));

    // Simultaneous reads from a fresh reset: D, I, D, I
    proc_reset = 1'b1;
    #1;
    proc_reset = 1'b0;
    i_read = 1'b1; i_addr = 28'h0000100;
    d_read = 1'b1; d_addr = 28'h0000200;
    serve_read(2'b10, "rr1");
    serve_read(2'b01, "rr2");
    serve_read(2'b10, "rr3");
    serve_read(2'b01, "rr4");

    // D write-back then allocate read while I keeps requesting; last was I so D wins
    d_read = 1'b0; d_write = 1'b1;
    d_addr = 28'h0000020; d_wdata = PAT_1234;
    step();
    check("wb grant", 128'(grant), 128'(2'b10));
    check("wb mem_write", 128'(mem_write), 128'(1'b1));
    check("wb mem_read", 128'(mem_read), 128'(1'b0));
    check("wb mem_addr", 128'(mem_addr), 128'(28'h0000020));
    check("wb mem_wdata", mem_wdata, PAT_1234);
    mem_ready = 1'b1;
    #1;
    check("wb d_ready", 128'(d_ready), 128'(1'b1));
    check("wb i_ready", 128'(i_ready), 128'(1'b0));
    step();
    mem_ready = 1'b0;
    d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000040;
    #1;
    check("alloc grant", 128'(grant), 128'(2'b10));
    check("alloc mem_read", 128'(mem_read), 128'(1'b1));
    check("alloc mem_addr", 128'(mem_addr), 128'(28'h0000040));
    step();
    check("alloc hold", 128'(grant), 128'(2'b10));
    mem_ready = 1'b1;
    #1;
    check("alloc d_ready", 128'(d_ready), 128'(1'b1));
    step();
    mem_ready = 1'b0;
    d_read = 1'b0;
    check("alloc released", 128'(grant), 128'(2'b00));
    step();
    check("i after alloc", 128'(grant), 128'(2'b01));
    check("i after alloc addr", 128'(mem_addr), 128'(28'h0000100));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    i_read = 1'b0;

    // Read and write together from D: treated as a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000008;
    step();
    check("rw grant", 128'(grant), 128'(2'b10));
    check("rw mem_write", 128'(mem_write), 128'(1'b1));
    check("rw mem_read", 128'(mem_read), 128'(1'b0));
    check("rw mem_addr", 128'(mem_addr), 128'(28'h0000008));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("rw held after write", 128'(grant), 128'(2'b10));
    d_read = 1'b0; d_write = 1'b0;
    step();
    check("rw abort release", 128'(grant), 128'(2'b00));

    // Reset mid-read with mem_ready still pending
    i_read = 1'b1; i_addr = 28'h0000030;
    step();
    check("mid grant", 128'(grant), 128'(2'b01));
    #2;
    proc_reset = 1'b1;
    #1;
    check("mid rst mem_read", 128'(mem_read), 128'(1'b0));
    check("mid rst grant", 128'(grant), 128'(2'b00));
    i_read = 1'b0;
    step();
    proc_reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("late i_ready", 128'(i_ready), 128'(1'b0));
    check("late d_ready", 128'(d_ready), 128'(1'b0));
    step();
    mem_ready = 1'b0;
    check("late grant", 128'(grant), 128'(2'b00));

    // mem_ready while idle
    mem_ready = 1'b1;
    #1;
    check("idle i_ready", 128'(i_ready), 128'(1'b0));
    check("idle d_ready", 128'(d_ready), 128'(1'b0));
    step();
    mem_ready = 1'b0;
    check("idle grant", 128'(grant), 128'(2'b00));
    check("idle mem_read", 128'(mem_read), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
